// File: rtl/mac_array_ctrl.sv
// Sequencer for an N-lane MAC array: clear, accumulate M operand beats, stream N result words, pulse done.
// Latency: start to done is 1 + M + N + 1 cycles when nothing stalls; abort returns to IDLE on the next edge.
// Backpressure: in_valid=0 stalls COMPUTE and out_ready=0 stalls OUTPUT, each for any number of cycles.
`timescale 1ns/1ps
module mac_array_ctrl #(
    parameter  int Width = 8,
    parameter  int N     = 4,
    parameter  int M     = 3,
    localparam int SW    = (M > 1) ? $clog2(M) : 1,
    localparam int OW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             acc_clear,
    output logic             acc_en,
    output logic [SW-1:0]    step_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OW-1:0]    out_sel,
    output logic             busy,
    output logic             done,
    output logic [Width-1:0] perf_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COMPUTE,
        S_OUTPUT,
        S_DONE
    } state_t;

    localparam logic [SW-1:0]    STEP_LAST = SW'(M - 1);
    localparam logic [OW-1:0]    SEL_LAST  = OW'(N - 1);
    localparam logic [Width-1:0] PERF_MAX  = {Width{1'b1}};

    state_t           state_q, state_nxt;
    logic [SW-1:0]    step_q, step_nxt;
    logic [OW-1:0]    sel_q, sel_nxt;
    logic [Width-1:0] perf_q, perf_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            sel_q   <= '0;
            perf_q  <= '0;
        end else begin
            state_q <= state_nxt;
            step_q  <= step_nxt;
            sel_q   <= sel_nxt;
            perf_q  <= perf_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        step_nxt  = step_q;
        sel_nxt   = sel_q;
        perf_nxt  = perf_q;
        in_ready  = 1'b0;
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Counters are zeroed on the way into CLEAR so CLEAR already shows a fresh job.
                if (start) begin
                    state_nxt = S_CLEAR;
                    step_nxt  = '0;
                    sel_nxt   = '0;
                    perf_nxt  = '0;
                end
            end
            S_CLEAR: begin
                busy      = 1'b1;
                acc_clear = 1'b1;
                step_nxt  = '0;
                sel_nxt   = '0;
                perf_nxt  = '0;
                state_nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                acc_en   = in_valid & ~abort;
                if (perf_q != PERF_MAX) begin
                    perf_nxt = perf_q + Width'(1);
                end
                if (in_valid) begin
                    if (step_q == STEP_LAST) begin
                        step_nxt  = '0;
                        state_nxt = S_OUTPUT;
                    end else begin
                        step_nxt = step_q + SW'(1);
                    end
                end
            end
            S_OUTPUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    if (sel_q == SEL_LAST) begin
                        sel_nxt   = '0;
                        state_nxt = S_DONE;
                    end else begin
                        sel_nxt = sel_q + OW'(1);
                    end
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort wins over start and both handshakes; the cycle count of the cancelled job is kept.
        if (abort) begin
            state_nxt = S_IDLE;
            step_nxt  = '0;
            sel_nxt   = '0;
            perf_nxt  = perf_q;
        end
    end

    assign step_idx    = step_q;
    assign out_sel     = sel_q;
    assign perf_cycles = perf_q;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Randomized bench for mac_array_ctrl: two instances (M=3,N=4,Width=8 and M=1,N=1,Width=3)
// checked cycle by cycle against an expected trace built from each job's stall pattern.
`timescale 1ns/1ps
module tb_mac_array_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       st0, ab0, iv0, or0, ir0, ae0, ac0, ov0, bs0, dn0;
    logic [1:0] sp0, os0;
    logic [7:0] pf0;
    logic       st1, ab1, iv1, or1, ir1, ae1, ac1, ov1, bs1, dn1;
    logic       sp1, os1;
    logic [2:0] pf1;

    mac_array_ctrl #(.Width(8), .N(4), .M(3)) dut0 (
        .clk(clk), .rst(rst), .start(st0), .abort(ab0),
        .in_valid(iv0), .in_ready(ir0), .acc_clear(ac0), .acc_en(ae0),
        .step_idx(sp0), .out_valid(ov0), .out_ready(or0), .out_sel(os0),
        .busy(bs0), .done(dn0), .perf_cycles(pf0)
    );

    mac_array_ctrl #(.Width(3), .N(1), .M(1)) dut1 (
        .clk(clk), .rst(rst), .start(st1), .abort(ab1),
        .in_valid(iv1), .in_ready(ir1), .acc_clear(ac1), .acc_en(ae1),
        .step_idx(sp1), .out_valid(ov1), .out_ready(or1), .out_sel(os1),
        .busy(bs1), .done(dn1), .perf_cycles(pf1)
    );

    int checks = 0;
    int errors = 0;
    int cnt = 0;
    int abort_at = -1;
    int rst_at = -1;
    int m_perf [2];
    bit iv_pat [$];
    bit or_pat [$];

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // {in_ready, acc_en, acc_clear, out_valid, busy, done, step_idx[1:0], out_sel[1:0], perf[7:0]}
    function automatic logic [17:0] vec(bit ir, bit ae, bit ac, bit ov, bit bs, bit dn,
                                        int stp, int sl, int pf);
        return {ir, ae, ac, ov, bs, dn, 2'(stp), 2'(sl), 8'(pf)};
    endfunction

    function automatic logic [17:0] obs(int d);
        if (d == 0) return {ir0, ae0, ac0, ov0, bs0, dn0, sp0, os0, pf0};
        return {ir1, ae1, ac1, ov1, bs1, dn1, 1'b0, sp1, 1'b0, os1, 5'b0, pf1};
    endfunction

    function automatic bit next_iv(int p);
        if (iv_pat.size() > 0) return iv_pat.pop_front();
        return $urandom_range(99) < p;
    endfunction

    function automatic bit next_or(int p);
        if (or_pat.size() > 0) return or_pat.pop_front();
        return $urandom_range(99) < p;
    endfunction

    function automatic bit rb();
        return $urandom_range(1) == 1;
    endfunction

    // One cycle on instance d. code: 0 normal, 1 aborted this cycle, 2 reset pulsed this cycle.
    task automatic cyc(input int d, input bit st, input bit iv, input bit orr,
                       input logic [17:0] ev, input string tag, output int code);
        bit ab;
        code = 0;
        ab = (cnt == abort_at);
        st0 = (d == 0) && st;  ab0 = (d == 0) && ab;  iv0 = (d == 0) && iv;  or0 = (d == 0) && orr;
        st1 = (d == 1) && st;  ab1 = (d == 1) && ab;  iv1 = (d == 1) && iv;  or1 = (d == 1) && orr;
        if (cnt == rst_at) begin
            #2 rst = 1'b1;
            #1 check($sformatf("%s_async_rst[%0d]", tag, cnt), obs(d), 18'h0);
            m_perf[0] = 0;
            m_perf[1] = 0;
            st0 = 0; st1 = 0;
            @(posedge clk);
            #1 rst = 1'b0;
            code = 2;
        end else begin
            if (ab) begin
                ev[16] = 1'b0;
                code = 1;
            end
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, cnt), obs(d), ev);
            @(posedge clk);
            #1;
        end
        cnt++;
    endtask

    task automatic job_body(input int d, input int ivp, input int orp, output int code);
        int m, n, pmax, beats, hs, cc;
        bit iv, orr;
        m = (d == 0) ? 3 : 1;
        n = (d == 0) ? 4 : 1;
        pmax = (d == 0) ? 255 : 7;
        beats = 0; hs = 0; cc = 0;
        cyc(d, 1, rb(), rb(), vec(0,0,0,0,0,0,0,0,m_perf[d]), "idle_start", code);
        if (code != 0) return;
        m_perf[d] = 0;
        cyc(d, rb(), rb(), rb(), vec(0,0,1,0,1,0,0,0,0), "clear", code);
        if (code != 0) return;
        while (beats < m) begin
            iv = next_iv(ivp);
            cyc(d, rb(), iv, rb(), vec(1,iv,0,0,1,0,beats,0,(cc > pmax) ? pmax : cc), "compute", code);
            if (code == 1) m_perf[d] = (cc > pmax) ? pmax : cc;
            if (code != 0) return;
            beats += int'(iv);
            cc++;
        end
        m_perf[d] = (cc > pmax) ? pmax : cc;
        while (hs < n) begin
            orr = next_or(orp);
            cyc(d, rb(), rb(), orr, vec(0,0,0,1,1,0,0,hs,m_perf[d]), "output", code);
            if (code != 0) return;
            hs += int'(orr);
        end
        cyc(d, 1, rb(), rb(), vec(0,0,0,0,1,1,0,0,m_perf[d]), "done", code);
    endtask

    task automatic job(input int d, input int ab_at, input int r_at, input int ivp, input int orp);
        int code;
        cnt = 0;
        abort_at = ab_at;
        rst_at = r_at;
        job_body(d, ivp, orp, code);
        cyc(d, 0, rb(), rb(), vec(0,0,0,0,0,0,0,0,m_perf[d]), "idle_after", code);
        abort_at = -1;
        rst_at = -1;
        iv_pat.delete();
        or_pat.delete();
    endtask

    initial begin
        rst = 1'b1;
        st0 = 0; ab0 = 0; iv0 = 0; or0 = 0;
        st1 = 0; ab1 = 0; iv1 = 0; or1 = 0;
        m_perf[0] = 0;
        m_perf[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_dut0", obs(0), 18'h0);
        check("reset_dut1", obs(1), 18'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        job(0, -1, -1, 100, 100);                       // nominal job
        iv_pat = '{1, 1, 0, 0, 1};
        job(0, -1, -1, 100, 100);                       // input stall, perf 5
        or_pat = '{1, 1, 0, 0, 0, 1, 1};
        job(0, -1, -1, 100, 100);                       // output backpressure at out_sel 2
        iv_pat = '{1, 1};
        job(0, 3, -1, 100, 100);                        // abort at step 1 with a beat offered
        job(0, -1, -1, 100, 100);
        job(0, -1, 6, 100, 100);                        // async reset inside OUTPUT
        job(0, -1, -1, 100, 100);
        job(0, 0, -1, 100, 100);                        // start with abort in IDLE
        job(1, -1, -1, 100, 100);                       // M=1,N=1: done 4 cycles after start
        for (int i = 0; i < 10; i++) iv_pat.push_back(1'b0);
        iv_pat.push_back(1'b1);
        job(1, -1, -1, 100, 100);                       // 3-bit counter saturates at 7
        for (int i = 0; i < 300; i++) iv_pat.push_back(1'b0);
        job(0, -1, -1, 100, 100);                       // 8-bit counter saturates at 255

        for (int i = 0; i < 40; i++) begin
            int d, a;
            d = $urandom_range(1);
            a = ($urandom_range(3) == 0) ? $urandom_range(1, 12) : -1;
            job(d, a, -1, $urandom_range(30, 100), $urandom_range(30, 100));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
